// File: rtl/mssd_frame_tx.sv
// Serial frame transmitter feeding the MSSD detector's single-bit input line.
// Latency: start bit on sout the cycle after start is sampled; ready returns 7+len+IDLE_GAP cycles after acceptance.
// Backpressure: ready=0 from acceptance until the idle gap ends; start while ready=0 is dropped, never queued.
//
// Frame on o_sout (MSB first per field, line idles high):
//   start(0) | dest[1:0] | len[3:0] | payload[len-1:0] | IDLE_GAP high cycles
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      synchronous reset, active-high, overrides everything
//   i_start    request strobe, taken only when o_ready=1
//   i_dest     2-bit destination, captured on acceptance
//   i_len      4-bit payload bit count (0..15), captured on acceptance
//   i_payload  15 payload bits, only [len-1:0] are sent
//   i_abort    ends the frame in flight; line returns high, full gap follows
//   o_sout     registered serial line, idles high
//   o_ready    high in IDLE, able to accept a request
//   o_busy     high while a frame bit is on o_sout
//   o_done     one-cycle pulse in the first gap cycle after a normal frame
module mssd_frame_tx #(
  parameter int IDLE_GAP = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_dest,
  input  logic [3:0]  i_len,
  input  logic [14:0] i_payload,
  input  logic        i_abort,
  output logic        o_sout,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done
);

  // Shadow copy of the accepted request; the live inputs are never used
  // after acceptance so the requester may change them freely.
  typedef struct packed {
    logic [1:0]  dest;
    logic [3:0]  len;
    logic [14:0] payload;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DEST  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // The gap counter counts down to zero inclusive, so it is loaded with
  // one less than the number of gap cycles.
  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP - 1);

  state_t     r_state;
  req_t       r_req;
  logic [3:0] r_cnt;
  logic       r_sout;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;

  // Index of the next bit within the current field. Only consulted while
  // r_cnt is non-zero, so it never underflows when used.
  logic [3:0] w_cnt_m1;
  // Index of the first payload bit; only consulted when len is non-zero.
  logic [3:0] w_len_m1;

  assign w_cnt_m1 = r_cnt - 4'd1;
  assign w_len_m1 = r_req.len - 4'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_cnt   <= 4'd0;
      r_sout  <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // r_busy is exactly "state in START..DATA", so it gates abort.
      if (r_busy && i_abort) begin
        r_state <= S_GAP;
        r_cnt   <= GAP_LOAD;
        r_sout  <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state       <= S_START;
              r_req.dest    <= i_dest;
              r_req.len     <= i_len;
              r_req.payload <= i_payload;
              r_sout        <= 1'b0;
              r_ready       <= 1'b0;
              r_busy        <= 1'b1;
            end
          end

          S_START: begin
            r_state <= S_DEST;
            r_cnt   <= 4'd1;
            r_sout  <= r_req.dest[1];
          end

          S_DEST: begin
            if (r_cnt == 4'd0) begin
              r_state <= S_LEN;
              r_cnt   <= 4'd3;
              r_sout  <= r_req.len[3];
            end else begin
              r_cnt  <= w_cnt_m1;
              r_sout <= r_req.dest[w_cnt_m1[0]];
            end
          end

          S_LEN: begin
            if (r_cnt != 4'd0) begin
              r_cnt  <= w_cnt_m1;
              r_sout <= r_req.len[w_cnt_m1[1:0]];
            end else if (r_req.len != 4'd0) begin
              r_state <= S_DATA;
              r_cnt   <= w_len_m1;
              r_sout  <= r_req.payload[w_len_m1];
            end else begin
              // Zero-length payload: the frame ends after the length field.
              r_state <= S_GAP;
              r_cnt   <= GAP_LOAD;
              r_sout  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end

          S_DATA: begin
            if (r_cnt == 4'd0) begin
              r_state <= S_GAP;
              r_cnt   <= GAP_LOAD;
              r_sout  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt  <= w_cnt_m1;
              r_sout <= r_req.payload[w_cnt_m1];
            end
          end

          S_GAP: begin
            if (r_cnt == 4'd0) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end else begin
              r_cnt <= w_cnt_m1;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_sout  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sout  = r_sout;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_mssd_frame_tx.sv
// Directed bench for mssd_frame_tx with IDLE_GAP=2.
// Inputs are driven and outputs sampled on the falling edge; the check made
// n falling edges after a request was driven shows frame offset n-1.
module tb_mssd_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  dest;
  logic [3:0]  len;
  logic [14:0] payload;
  logic        abort;
  logic        sout;
  logic        ready;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  mssd_frame_tx #(.IDLE_GAP(2)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_dest    (dest),
    .i_len     (len),
    .i_payload (payload),
    .i_abort   (abort),
    .o_sout    (sout),
    .o_ready   (ready),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Check frame offsets first..last; bits[n-1] is offset 0 (the start bit).
  task automatic frame_bits(input string tag, input logic [21:0] bits, input int n,
                            input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cyc();
      chk($sformatf("%s sout@%0d", tag, i), {31'd0, sout}, {31'd0, bits[n-1-i]});
      chk($sformatf("%s busy@%0d", tag, i), {31'd0, busy}, 32'd1);
      chk($sformatf("%s ready@%0d", tag, i), {31'd0, ready}, 32'd0);
      chk($sformatf("%s done@%0d", tag, i), {31'd0, done}, 32'd0);
    end
  endtask

  // Three cycles after the last frame bit: first gap cycle (done pulse when
  // the frame completed normally), second gap cycle, then ready again.
  task automatic tail(input string tag, input logic exp_done);
    cyc();
    chk({tag, " gap1 sout"}, {31'd0, sout}, 32'd1);
    chk({tag, " gap1 busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " gap1 done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, " gap1 ready"}, {31'd0, ready}, 32'd0);
    cyc();
    chk({tag, " gap2 sout"}, {31'd0, sout}, 32'd1);
    chk({tag, " gap2 done"}, {31'd0, done}, 32'd0);
    chk({tag, " gap2 ready"}, {31'd0, ready}, 32'd0);
    cyc();
    chk({tag, " rdy sout"}, {31'd0, sout}, 32'd1);
    chk({tag, " rdy ready"}, {31'd0, ready}, 32'd1);
    chk({tag, " rdy busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; dest = 2'd0; len = 4'd0; payload = 15'd0; abort = 1'b0;
    cyc();
    cyc();
    chk("reset sout", {31'd0, sout}, 32'd1);
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // Ten idle cycles after reset.
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("idle sout@%0d", i), {31'd0, sout}, 32'd1);
      chk($sformatf("idle ready@%0d", i), {31'd0, ready}, 32'd1);
      chk($sformatf("idle busy@%0d", i), {31'd0, busy}, 32'd0);
      chk($sformatf("idle done@%0d", i), {31'd0, done}, 32'd0);
    end

    // Abort while idle changes nothing.
    abort = 1'b1;
    cyc();
    chk("idle abort ready", {31'd0, ready}, 32'd1);
    chk("idle abort sout", {31'd0, sout}, 32'd1);
    chk("idle abort busy", {31'd0, busy}, 32'd0);
    abort = 1'b0;

    // Frame A: dest=10 len=3 payload=5 -> 0 | 10 | 0011 | 101.
    // Inputs are scrambled after acceptance and a stray start is ignored.
    start = 1'b1; dest = 2'b10; len = 4'd3; payload = 15'h0005;
    frame_bits("A", 22'(10'b0100011101), 10, 0, 0);
    start = 1'b0; dest = 2'b00; len = 4'd15; payload = 15'h0000;
    frame_bits("A", 22'(10'b0100011101), 10, 1, 3);
    start = 1'b1;
    frame_bits("A", 22'(10'b0100011101), 10, 4, 4);
    start = 1'b0;
    frame_bits("A", 22'(10'b0100011101), 10, 5, 9);
    tail("A", 1'b1);

    // Frame B: dest=01 len=0, payload ignored -> 0 | 01 | 0000.
    start = 1'b1; dest = 2'b01; len = 4'd0; payload = 15'h7FFF;
    frame_bits("B", 22'(7'b0010000), 7, 0, 0);
    start = 1'b0;
    frame_bits("B", 22'(7'b0010000), 7, 1, 6);
    tail("B", 1'b1);

    // Frame C: dest=11 len=15 payload=7FFF with start held high.
    start = 1'b1; dest = 2'b11; len = 4'd15; payload = 15'h7FFF;
    frame_bits("C", 22'h1FFFFF, 22, 0, 21);
    tail("C", 1'b1);
    // Start is still high: the following frame begins on the next edge,
    // after the two gap cycles and the one IDLE cycle that samples start.
    // Frame D: dest=00 len=2 payload=01 -> 0 | 00 | 0010 | 01.
    dest = 2'b00; len = 4'd2; payload = 15'h0001;
    frame_bits("D", 22'(9'b000001001), 9, 0, 0);
    start = 1'b0;
    frame_bits("D", 22'(9'b000001001), 9, 1, 8);
    tail("D", 1'b1);

    // Frame E: dest=10 len=8 payload=A5, aborted during the 3rd data bit.
    start = 1'b1; dest = 2'b10; len = 4'd8; payload = 15'h00A5;
    frame_bits("E", 22'(10'b0101000101), 10, 0, 0);
    start = 1'b0;
    frame_bits("E", 22'(10'b0101000101), 10, 1, 9);
    abort = 1'b1; start = 1'b1;
    cyc();
    chk("E abort sout", {31'd0, sout}, 32'd1);
    chk("E abort busy", {31'd0, busy}, 32'd0);
    chk("E abort done", {31'd0, done}, 32'd0);
    chk("E abort ready", {31'd0, ready}, 32'd0);
    abort = 1'b0;
    cyc();
    chk("E gap2 sout", {31'd0, sout}, 32'd1);
    chk("E gap2 done", {31'd0, done}, 32'd0);
    chk("E gap2 ready", {31'd0, ready}, 32'd0);
    start = 1'b0;
    cyc();
    chk("E rdy ready", {31'd0, ready}, 32'd1);
    chk("E rdy sout", {31'd0, sout}, 32'd1);
    cyc();
    chk("E no queued ready", {31'd0, ready}, 32'd1);
    chk("E no queued busy", {31'd0, busy}, 32'd0);
    chk("E no queued sout", {31'd0, sout}, 32'd1);

    // Frame F: dest=01 len=4, reset during the length field.
    start = 1'b1; dest = 2'b01; len = 4'd4; payload = 15'h000F;
    frame_bits("F", 22'(5'b00101), 5, 0, 0);
    start = 1'b0;
    frame_bits("F", 22'(5'b00101), 5, 1, 4);
    rst = 1'b1;
    cyc();
    chk("F rst sout", {31'd0, sout}, 32'd1);
    chk("F rst ready", {31'd0, ready}, 32'd1);
    chk("F rst busy", {31'd0, busy}, 32'd0);
    chk("F rst done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // Frame G right after reset: dest=11 len=1 payload=1 -> 0 | 11 | 0001 | 1.
    start = 1'b1; dest = 2'b11; len = 4'd1; payload = 15'h0001;
    frame_bits("G", 22'(8'b01100011), 8, 0, 0);
    start = 1'b0;
    frame_bits("G", 22'(8'b01100011), 8, 1, 7);
    tail("G", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
